// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry in-order result buffer behind the CR16 ALU,
// committing masked status flags into the PSR and evaluating condition codes.
module alu_result_stage #(
  parameter int P_WIDTH = 16
) (
  input  logic               I_CLK,
  input  logic               I_NRESET,
  input  logic               I_VALID,
  output logic               O_READY,
  input  logic [P_WIDTH-1:0] I_RESULT,
  input  logic [4:0]         I_STATUS,
  input  logic [4:0]         I_FLAG_MASK,
  input  logic [3:0]         I_DEST,
  input  logic               I_WB_EN,
  output logic               O_VALID,
  input  logic               I_READY,
  output logic [P_WIDTH-1:0] O_RESULT,
  output logic [3:0]         O_DEST,
  output logic               O_WB_EN,
  input  logic               I_FLUSH,
  output logic               O_PENDING,
  output logic [4:0]         O_PSR,
  input  logic [3:0]         I_COND,
  output logic               O_COND_TRUE
);

  typedef struct packed {
    logic [P_WIDTH-1:0] result;
    logic [4:0]         status;
    logic [4:0]         mask;
    logic [3:0]         dest;
    logic               wb_en;
  } entry_t;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  entry_t     in_e;
  logic [1:0] cnt_q, cnt_d;
  logic [4:0] psr_q, psr_d;
  logic       push;
  logic       pop;

  assign in_e.result = I_RESULT;
  assign in_e.status = I_STATUS;
  assign in_e.mask   = I_FLAG_MASK;
  assign in_e.dest   = I_DEST;
  assign in_e.wb_en  = I_WB_EN;

  assign O_READY   = (cnt_q != CNT_FULL);
  assign O_VALID   = (cnt_q != CNT_EMPTY);
  assign O_PENDING = (cnt_q != CNT_EMPTY);
  assign O_RESULT  = head_q.result;
  assign O_DEST    = head_q.dest;
  assign O_WB_EN   = head_q.wb_en;
  assign O_PSR     = psr_q;

  // A flush drops the same-cycle input, so it never counts as a push.
  assign push = I_VALID & O_READY & ~I_FLUSH;
  assign pop  = O_VALID & I_READY;

  always_comb begin
    psr_d = psr_q;
    if (pop) begin
      psr_d = (psr_q & ~head_q.mask) | (head_q.status & head_q.mask);
    end
  end

  // Slot 0 is always the head; a pop from full shifts the tail forward.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (I_FLUSH) begin
      cnt_d = CNT_EMPTY;
    end else begin
      unique case (cnt_q)
        CNT_EMPTY: begin
          if (push) begin
            head_d = in_e;
            cnt_d  = CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (push && pop) begin
            head_d = in_e;
          end else if (push) begin
            tail_d = in_e;
            cnt_d  = CNT_FULL;
          end else if (pop) begin
            cnt_d = CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (pop) begin
            head_d = tail_q;
            cnt_d  = CNT_ONE;
          end
        end
        default: begin
          cnt_d = CNT_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= CNT_EMPTY;
      psr_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      psr_q  <= psr_d;
    end
  end

  logic flg_c, flg_l, flg_f, flg_z, flg_n;
  assign flg_c = psr_q[0];
  assign flg_l = psr_q[1];
  assign flg_f = psr_q[2];
  assign flg_z = psr_q[3];
  assign flg_n = psr_q[4];

  always_comb begin
    O_COND_TRUE = 1'b0;
    unique case (I_COND)
      4'd0:  O_COND_TRUE = flg_z;
      4'd1:  O_COND_TRUE = ~flg_z;
      4'd2:  O_COND_TRUE = flg_c;
      4'd3:  O_COND_TRUE = ~flg_c;
      4'd4:  O_COND_TRUE = flg_l;
      4'd5:  O_COND_TRUE = ~flg_l;
      4'd6:  O_COND_TRUE = flg_n;
      4'd7:  O_COND_TRUE = ~flg_n;
      4'd8:  O_COND_TRUE = flg_f;
      4'd9:  O_COND_TRUE = ~flg_f;
      4'd10: O_COND_TRUE = ~flg_l & ~flg_z;
      4'd11: O_COND_TRUE = flg_l | flg_z;
      4'd12: O_COND_TRUE = ~flg_n & ~flg_z;
      4'd13: O_COND_TRUE = flg_n | flg_z;
      4'd14: O_COND_TRUE = 1'b1;
      4'd15: O_COND_TRUE = 1'b0;
      default: O_COND_TRUE = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed vectors with hand-computed expectations
// for the ALU result stage buffer, PSR commit and condition evaluation.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready;
  logic [15:0] i_result, o_result;
  logic [4:0]  i_status, i_mask, o_psr;
  logic [3:0]  i_dest, o_dest, i_cond;
  logic        i_wb_en, o_wb_en;
  logic        o_valid, i_ready, i_flush, o_pending, o_cond_true;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.P_WIDTH(16)) dut (
    .I_CLK(clk), .I_NRESET(rst_n),
    .I_VALID(i_valid), .O_READY(o_ready),
    .I_RESULT(i_result), .I_STATUS(i_status),
    .I_FLAG_MASK(i_mask), .I_DEST(i_dest),
    .I_WB_EN(i_wb_en), .O_VALID(o_valid),
    .I_READY(i_ready), .O_RESULT(o_result),
    .O_DEST(o_dest), .O_WB_EN(o_wb_en),
    .I_FLUSH(i_flush), .O_PENDING(o_pending),
    .O_PSR(o_psr), .I_COND(i_cond),
    .O_COND_TRUE(o_cond_true)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] r,
                       input logic [4:0] s, input logic [4:0] m);
    i_valid  = v;
    i_result = r;
    i_status = s;
    i_mask   = m;
    i_dest   = r[3:0];
    i_wb_en  = 1'b1;
  endtask

  logic [15:0] ctab;

  initial begin
    rst_n = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    i_cond = 4'd0;
    drive(1'b0, 16'h0, 5'h0, 5'h0);
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_pending", o_pending, 0);
    chk("rst_psr", o_psr, 0);
    chk("rst_result", o_result, 0);
    chk("rst_dest", o_dest, 0);
    chk("rst_wben", o_wb_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", o_ready, 1);

    // single op
    drive(1'b1, 16'h0005, 5'b01000, 5'b11111);
    tick();
    chk("t1_valid", o_valid, 1);
    chk("t1_result", o_result, 16'h0005);
    chk("t1_psr_pre", o_psr, 0);
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    chk("t1_empty", o_valid, 0);
    chk("t1_psr", o_psr, 5'b01000);
    i_cond = 4'd0; #1;
    chk("t1_eq", o_cond_true, 1);
    i_cond = 4'd1; #1;
    chk("t1_ne", o_cond_true, 0);

    // mask
    drive(1'b1, 16'h0011, 5'b11111, 5'b11111);
    tick();
    i_valid = 1'b0;
    tick();
    chk("t2_psr_all", o_psr, 5'b11111);
    drive(1'b1, 16'h0012, 5'b00000, 5'b01000);
    tick();
    i_valid = 1'b0;
    tick();
    chk("t2_psr_mask", o_psr, 5'b10111);
    i_cond = 4'd10; #1;
    chk("t2_lo", o_cond_true, 0);
    i_cond = 4'd11; #1;
    chk("t2_hs", o_cond_true, 1);

    // backpressure
    i_ready = 1'b0;
    drive(1'b1, 16'h00A0, 5'h0, 5'h0);
    tick();
    chk("bp_rdy_a", o_ready, 1);
    drive(1'b1, 16'h00B0, 5'h0, 5'h0);
    tick();
    chk("bp_rdy_b", o_ready, 0);
    drive(1'b1, 16'h00C0, 5'h0, 5'h0);
    tick();
    chk("bp_hold_rdy", o_ready, 0);
    chk("bp_head_a", o_result, 16'h00A0);
    i_ready = 1'b1;
    tick();
    chk("bp_rdy_up", o_ready, 1);
    chk("bp_head_b", o_result, 16'h00B0);
    tick();
    i_valid = 1'b0;
    chk("bp_head_c", o_result, 16'h00C0);
    chk("bp_dest_c", o_dest, 4'h0);
    chk("bp_valid_c", o_valid, 1);
    tick();
    chk("bp_drain", o_valid, 0);
    chk("bp_psr", o_psr, 5'b10111);

    // streaming: one retire per cycle, occupancy stays 1
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 16'(k), 5'(k), 5'b10011);
      tick();
      chk("st_result", o_result, k);
      chk("st_ready", o_ready, 1);
    end
    i_valid = 1'b0;
    tick();
    chk("st_pending", o_pending, 0);
    chk("st_psr", o_psr, 5'b00100);

    // flush
    i_ready = 1'b0;
    drive(1'b1, 16'h0A0A, 5'b11111, 5'b00001);
    tick();
    drive(1'b1, 16'h0B0B, 5'b11111, 5'b11111);
    tick();
    chk("fl_full", o_ready, 0);
    drive(1'b1, 16'h0C0C, 5'b11111, 5'b11111);
    i_ready = 1'b1;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("fl_valid", o_valid, 0);
    chk("fl_pending", o_pending, 0);
    chk("fl_psr", o_psr, 5'b00101);
    tick();
    chk("fl_psr_hold", o_psr, 5'b00101);
    chk("fl_still_empty", o_valid, 0);

    // full condition table against PSR = 00101
    ctab = 16'b0101_0101_1010_0110;
    for (int c = 0; c < 16; c++) begin
      i_cond = 4'(c); #1;
      chk("cond_tab", o_cond_true, ctab[c]);
    end

    // async reset mid-stream
    drive(1'b1, 16'h0015, 5'b10101, 5'b11111);
    tick();
    i_valid = 1'b0;
    tick();
    chk("ar_psr_set", o_psr, 5'b10101);
    i_ready = 1'b0;
    drive(1'b1, 16'h0021, 5'h0, 5'h0);
    tick();
    drive(1'b1, 16'h0022, 5'h0, 5'h0);
    tick();
    i_valid = 1'b0;
    chk("ar_full", o_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", o_valid, 0);
    chk("ar_pending", o_pending, 0);
    chk("ar_psr", o_psr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_ready", o_ready, 1);
    chk("ar_result", o_result, 0);
    chk("ar_empty", o_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result stage directly downstream of the CR16 ALU. It captures each ALU result (O_C and O_STATUS) with its writeback tag into a 2-entry in-order buffer, using valid/ready handshakes on both sides. It commits selected status bits into the architectural processor status register (PSR) when an entry retires to writeback. It also evaluates the 4-bit CR16 condition code against the committed PSR for the branch, jump and Scond logic.

## Interface
- P_WIDTH, 16, width of result datapath (matches ALU P_WIDTH)
- I_CLK  in  1  clock; all state updates on rising edge
- I_NRESET  in  1  asynchronous, active-low reset
- I_VALID  in  1  upstream holds a valid ALU result this cycle
- O_READY  out  1  stage can accept; asserted iff occupancy < 2
- I_RESULT  in  P_WIDTH  ALU O_C
- I_STATUS  in  5  ALU O_STATUS; bit 0 C, 1 L, 2 F, 3 Z, 4 N
- I_FLAG_MASK  in  5  per-bit PSR update enable for this op (same bit order)
- I_DEST  in  4  destination register index
- I_WB_EN  in  1  entry writes the register file
- O_VALID  out  1  head entry valid toward writeback
- I_READY  in  1  writeback accepts head entry
- O_RESULT  out  P_WIDTH  head entry result
- O_DEST  out  4  head entry destination
- O_WB_EN  out  1  head entry write enable
- I_FLUSH  in  1  discard all non-retiring entries
- O_PENDING  out  1  occupancy != 0 (PSR not yet final)
- O_PSR  out  5  committed flags C,L,F,Z,N
- I_COND  in  4  condition code to evaluate
- O_COND_TRUE  out  1  I_COND satisfied by O_PSR

## Operation
- Accept: I_VALID & O_READY at an edge pushes {I_RESULT, I_STATUS, I_FLAG_MASK, I_DEST, I_WB_EN} at the tail.
- Retire: O_VALID & I_READY at an edge pops the head. At that edge, for each bit i: PSR[i] <= I_FLAG_MASK_of_head[i] ? status_of_head[i] : PSR[i].
- Order is strictly FIFO. Occupancy is 0..2.
- Accept and retire in the same cycle: occupancy is unchanged and order is preserved. When occupancy is 1, the new entry becomes head on the next cycle.
- Full (2): O_READY=0, so I_VALID is ignored. A retire in this cycle frees a slot, and O_READY rises the next cycle.
- Empty: O_VALID=0. O_RESULT, O_DEST and O_WB_EN hold their last values and are don't-care.
- Flush: a retire handshake in the flush cycle completes normally, including its PSR update. Every other entry and any same-cycle input are dropped, and occupancy becomes 0 next cycle. The PSR is never updated by dropped entries.
- Condition evaluation is combinational from O_PSR and I_COND:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - 10 LO: !L&!Z
  - 11 HS: L|Z
  - 12 LT: !N&!Z
  - 13 GE: N|Z
  - 14 UC: 1
  - 15 never: 0
- Hazard rule: O_COND_TRUE reflects only committed flags. The controller must not act on it while O_PENDING=1.
- Reset (I_NRESET=0, asynchronous): occupancy 0, O_VALID 0, O_READY 1 after release, O_PENDING 0, O_PSR 0, O_RESULT 0, O_DEST 0, O_WB_EN 0, internal entries 0. Reset mid-transfer discards all entries, and the PSR returns to 0.

## Timing
- Accept-to-output latency is 1 cycle. An entry accepted at edge k into an empty stage drives O_VALID=1 from edge k.
- PSR update from a retire at edge k is visible on O_PSR and O_COND_TRUE from edge k.
- O_READY, O_VALID and O_PENDING are driven from registered state only. There is no combinational path from I_READY or I_VALID to O_READY, or from I_VALID to O_VALID.
- O_COND_TRUE is the only combinational output; its only inputs are I_COND and the PSR register.
- Sustained throughput is 1 entry/cycle with I_READY held high.

## Test plan
- Reset then single op: accept RESULT=0x0005, STATUS=0b01000 (Z), MASK=0b11111. Required: O_VALID one cycle later, O_RESULT=0x0005. After retire, O_PSR=0b01000, and I_COND=0 gives O_COND_TRUE=1 while I_COND=1 gives 0.
- Mask: with PSR=0b11111, retire STATUS=0b00000, MASK=0b01000. Required: O_PSR=0b10111, and I_COND=10 (LO) gives O_COND_TRUE=0.
- Backpressure: I_READY=0 and push 3 entries A,B,C. Required: A and B accepted, O_READY=0 from the cycle after B, C held. Then I_READY=1. Required: retire order A,B,C with no loss, and O_READY=1 the cycle after A retires.
- Streaming: I_VALID=I_READY=1 for 8 cycles with results 1..8. Required: occupancy stays 1, one retire per cycle, and the PSR after the last retire matches entry 8's masked status.
- Flush: occupancy 2 (A head, B tail), I_READY=1 and I_FLUSH=1 with C presented. Required: A retires and updates the PSR, B and C are dropped, and O_VALID=0 and O_PENDING=0 the next cycle.
- Async reset mid-stream: assert I_NRESET=0 between edges with occupancy 2 and PSR=0b10101. Required: O_VALID, O_PENDING and O_PSR go to 0 immediately without a clock edge, and O_READY=1 after release.
